// File: rtl/multi_wave_renderer.sv
// Animated triangle-wave bar layers: per-channel offsets advanced once per frame,
// plus a 2-stage pixel pipeline producing one draw bit per layer.
module multi_wave_renderer #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned BAR_WIDTH     = 40,
    parameter int unsigned VISIBLE_WIDTH = 25,
    parameter int unsigned LUT_DEPTH     = 10,
    parameter int unsigned AMP_STEP      = 10,
    parameter int unsigned SPEED_W       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [9:0]                pix_x,
    input  logic [9:0]                pix_y,
    input  logic                      display_on,
    input  logic [NUM_CH*SPEED_W-1:0] speed,
    input  logic [NUM_CH-1:0]         dir,
    input  logic                      pause,
    input  logic [NUM_CH*10-1:0]      base_y,
    output logic [NUM_CH-1:0]         draw,
    output logic                      any_draw,
    output logic                      display_on_d,
    output logic [NUM_CH*10-1:0]      offset,
    output logic [7:0]                frame_count
);

    localparam int unsigned PERIOD = BAR_WIDTH * LUT_DEPTH;
    localparam int unsigned ADDR_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam int unsigned BAR_W  = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    localparam logic [10:0]       PERIOD_L = 11'(PERIOD);
    localparam logic [9:0]        PERIOD_S = 10'(PERIOD);
    localparam logic [10:0]       BAR_L    = 11'(BAR_WIDTH);
    localparam logic [10:0]       AMP_L    = 11'(AMP_STEP);
    localparam logic [BAR_W:0]    VIS_L    = (BAR_W + 1)'(VISIBLE_WIDTH);
    localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(LUT_DEPTH / 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        advance;
    logic [7:0]  fc_q, fc_d;
    logic [9:0]  off_q [NUM_CH];
    logic [9:0]  off_d [NUM_CH];
    logic [9:0]  step_w [NUM_CH];
    logic [10:0] fwd_w [NUM_CH];

    logic [ADDR_W-1:0] addr_d [NUM_CH];
    logic [ADDR_W-1:0] addr_s1_q [NUM_CH];
    logic [BAR_W-1:0]  bar_d [NUM_CH];
    logic [BAR_W-1:0]  bar_s1_q [NUM_CH];
    logic [10:0]       sum_w [NUM_CH];
    logic [10:0]       pos_w [NUM_CH];
    logic [9:0]        pix_y_s1_q;
    logic              disp_s1_q;

    logic [ADDR_W-1:0] diff_w [NUM_CH];
    logic [10:0]       h_w [NUM_CH];
    logic [10:0]       base_w [NUM_CH];
    logic [10:0]       lo_w [NUM_CH];
    logic [NUM_CH-1:0] draw_d, draw_q;
    logic              any_draw_q, disp_d_q;

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (pause) state_d = ST_HOLD;
                    else       advance = 1'b1;
                end
                ST_HOLD: if (!pause) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign fc_d = advance ? fc_q + 8'd1 : fc_q;

    // Speed 0 is treated as 1 so a layer never stalls while running.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            step_w[i] = (speed[i*SPEED_W +: SPEED_W] == '0) ? 10'd1
                                                             : 10'(speed[i*SPEED_W +: SPEED_W]);
            fwd_w[i]  = {1'b0, off_q[i]} + {1'b0, step_w[i]};
            off_d[i]  = off_q[i];
            if (advance) begin
                if (!dir[i]) begin
                    off_d[i] = (fwd_w[i] >= PERIOD_L) ? 10'(fwd_w[i] - PERIOD_L) : fwd_w[i][9:0];
                end else begin
                    off_d[i] = (off_q[i] < step_w[i]) ? off_q[i] + PERIOD_S - step_w[i]
                                                       : off_q[i] - step_w[i];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum_w[i]  = {1'b0, pix_x} + {1'b0, off_q[i]};
            pos_w[i]  = sum_w[i] % PERIOD_L;
            addr_d[i] = ADDR_W'(pos_w[i] / BAR_L);
            bar_d[i]  = BAR_W'(pos_w[i] % BAR_L);
        end
    end

    // A bar of height h spans rows [base_y-h, base_y); the top clamps at row 0.
    always_comb begin
        draw_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            diff_w[i] = (addr_s1_q[i] >= HALF_A) ? addr_s1_q[i] - HALF_A : HALF_A - addr_s1_q[i];
            h_w[i]    = 11'(diff_w[i]) * AMP_L;
            base_w[i] = {1'b0, base_y[i*10 +: 10]};
            lo_w[i]   = (h_w[i] > base_w[i]) ? '0 : base_w[i] - h_w[i];
            draw_d[i] = disp_s1_q
                        && ({1'b0, bar_s1_q[i]} < VIS_L)
                        && ({1'b0, pix_y_s1_q} >= lo_w[i])
                        && ({1'b0, pix_y_s1_q} < base_w[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fc_q       <= '0;
            pix_y_s1_q <= '0;
            disp_s1_q  <= 1'b0;
            draw_q     <= '0;
            any_draw_q <= 1'b0;
            disp_d_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                off_q[i]     <= 10'(i * (PERIOD / NUM_CH));
                addr_s1_q[i] <= '0;
                bar_s1_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            pix_y_s1_q <= pix_y;
            disp_s1_q  <= display_on;
            draw_q     <= draw_d;
            any_draw_q <= |draw_d;
            disp_d_q   <= disp_s1_q;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                off_q[i]     <= off_d[i];
                addr_s1_q[i] <= addr_d[i];
                bar_s1_q[i]  <= bar_d[i];
            end
        end
    end

    always_comb begin
        offset = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            offset[i*10 +: 10] = off_q[i];
        end
    end

    assign draw         = draw_q;
    assign any_draw     = any_draw_q;
    assign display_on_d = disp_d_q;
    assign frame_count  = fc_q;

endmodule

// File: doc/multi_wave_renderer.md
Name: multi_wave_renderer

Overview:
- Parametrised successor to the single sine-wave scene and its vsync-clocked offset logic.
- Animates NUM_CH independent triangle-wave bar layers. Each layer has its own speed, direction and vertical baseline, and channel phases are staggered.
- All state runs on the pixel clock, advanced by a frame_tick strobe. Pixel evaluation is a 2-stage pipeline.
- Sits between hvsync_generator and the top-level colour mux; the top level assigns each draw bit a colour.

Parameters:
- NUM_CH, 2, number of wave layers.
- BAR_WIDTH, 40, pixels per bar column.
- VISIBLE_WIDTH, 25, lit pixels per bar; must be ≤ BAR_WIDTH.
- LUT_DEPTH, 10, bars per wave period.
- AMP_STEP, 10, height step; bar height h(k) = AMP_STEP*|k - LUT_DEPTH/2|.
- SPEED_W, 4, width of per-channel speed field; requires 2^SPEED_W - 1 < PERIOD.
- PERIOD (derived localparam), BAR_WIDTH*LUT_DEPTH = 400, offset modulus.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per frame (start of vblank)
- pix_x  in  10  current pixel column from hvsync_generator
- pix_y  in  10  current pixel row
- display_on  in  1  active-video flag
- speed  in  NUM_CH*SPEED_W  per-channel speed; channel i occupies bits [i*SPEED_W +: SPEED_W]
- dir  in  NUM_CH  per-channel direction; 0 = forward, 1 = reverse
- pause  in  1  freeze all offsets
- base_y  in  NUM_CH*10  per-channel baseline row; bars grow upward from it
- draw  out  NUM_CH  per-channel pixel hit, 2-cycle latency
- any_draw  out  1  OR of draw
- display_on_d  out  1  display_on delayed 2 cycles, aligned with draw
- offset  out  NUM_CH*10  current per-channel offset (debug)
- frame_count  out  8  frames advanced

Behaviour:
- Reset:
  - state = IDLE.
  - offset_i = i*(PERIOD/NUM_CH), using integer division.
  - draw, any_draw, display_on_d and all pipeline registers = 0.
  - frame_count = 0.
  - Reset has priority over a simultaneous frame_tick.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: first frame_tick → RUN. Offsets do not change on this tick.
  - RUN, frame_tick with pause=1 → HOLD. Offsets unchanged on that tick.
  - RUN, frame_tick with pause=0 → advance every offset; frame_count += 1, wrapping 255→0.
  - HOLD, frame_tick with pause=0 → RUN. Offsets unchanged on that tick; advancing resumes on the next tick.
- pause, speed and dir are sampled only on frame_tick cycles. Changes between ticks have no effect.
- Advance rule:
  - d = (speed_i == 0) ? 1 : speed_i.
  - Forward: offset_i ← offset_i + d, minus PERIOD if the sum ≥ PERIOD.
  - Reverse: offset_i ← offset_i - d, plus PERIOD if the result would be < 0.
  - offset_i is always in [0, PERIOD-1].
- Pixel pipeline, stage 1 (registered):
  - pos_i = (pix_x + offset_i) mod PERIOD, exact for pix_x in 0..1023.
  - addr_i = pos_i / BAR_WIDTH.
  - bar_i = pos_i mod BAR_WIDTH.
  - pix_y and display_on are registered alongside.
- Pixel pipeline, stage 2 (registered):
  - h = h(addr_i).
  - lo = (h > base_y_i) ? 0 : base_y_i - h.
  - draw_i = display_on_s1 && bar_i < VISIBLE_WIDTH && pix_y_s1 ≥ lo && pix_y_s1 < base_y_i.
  - h = 0 gives no pixels.
- Latency: inputs at cycle t appear on draw, any_draw and display_on_d at cycle t+2.
  - Stage-1 offsets are sampled at cycle t. An offset update at t therefore affects pixels entering from t+1 onward.
- Outside display_on, draw = 0 regardless of geometry.

Test Plan:
- Reset, NUM_CH=2: offset = {0, 200}, frame_count = 0, draw = 0. First frame_tick leaves offsets at {0, 200}.
- speed_0=4, dir_0=0, ticks after start: offset_0 = 4, 8, …. From 396, one tick gives 0. frame_count wraps 255→0 after 256 advancing ticks.
- dir_0=1, speed_0=0 (d=1) at offset 0: next tick gives 399, then 398.
- pause=1 on a tick: offsets and frame_count hold for 3 ticks. pause=0 tick enters RUN with no advance; the next tick advances.
- offset_0=0, base_y_0=300, pix_x=0 (addr 0, h=50), pix_y=260: draw_0=1 exactly 2 cycles later. pix_y=249 → 0. pix_y=300 → 0. pix_x=30 (bar 30 ≥ 25) → 0.
- base_y_0=20, h=50: lo saturates to 0, so pix_y=0..19 draws. Toggling display_on gives display_on_d and draw gating delayed exactly 2 cycles.
